// File: rtl/sfx_arb_pkg.sv
// sfx_arb_pkg
// Shared types and constants for the SFX tone arbiter.
//   state_e   : arbiter FSM encoding (IDLE, PLAY, GAP)
//   TONE_W    : tone / frequency word width
//   LEN_W     : SFX length and counter width
//   DUTY_W    : PWM duty width
//   DUTY_OFF  : duty driven while silent
//   len_floor : maps a programmed length of 0 onto 1
package sfx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int TONE_W = 32;
  localparam int LEN_W  = 8;
  localparam int DUTY_W = 10;

  localparam logic [DUTY_W-1:0] DUTY_OFF = 10'd0;

  // A zero-length request still sounds for one tick.
  function automatic logic [LEN_W-1:0] len_floor(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(1) : len;
  endfunction

endpackage

// File: rtl/sfx_tone_arbiter_prio_pick.sv
// prio_pick
// Combinational fixed-priority picker; the lowest set index wins.
//   req_i    : request vector (N bits)
//   onehot_o : one-hot winner (zero when nothing requested)
//   idx_o    : binary index of the winner (zero when nothing requested)
//   valid_o  : high when any request bit is set
module prio_pick #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Scan from the top down so the last hit (lowest index) overrides.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        idx_o       = IW'(i);
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sfx_tone_arbiter.sv
// sfx_tone_arbiter
// Shares one tone PWM generator between background music and NUM_SFX
// sound-effect requesters. Each SFX plays for its programmed number of
// ticks, followed by GAP_TICKS of silence, then music resumes.
//   clk        : system clock
//   reset      : asynchronous reset, active low
//   tick       : one-cycle timing strobe; lengths count in ticks
//   music_tone : background-music frequency
//   music_en   : 0 silences background music
//   sfx_req    : one-cycle request pulse per requester
//   sfx_tone   : packed per-requester frequency, slice i = [32*i +: 32]
//   sfx_len    : packed per-requester length in ticks, slice i = [8*i +: 8]
//   tone       : frequency to the PWM generator
//   duty       : duty to the PWM generator
//   grant      : one-hot id of the SFX now playing
//   busy       : high while playing an SFX or in the silence gap
//   done       : one-cycle pulse on natural SFX completion
//   done_id    : index of the completed SFX, valid with done
module sfx_tone_arbiter
  import sfx_arb_pkg::*;
#(
  parameter int          NUM_SFX   = 4,
  parameter int          GAP_TICKS = 1,
  parameter logic [9:0]  DUTY_ON   = 10'd512
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tick,
  input  logic [31:0]                 music_tone,
  input  logic                        music_en,
  input  logic [NUM_SFX-1:0]          sfx_req,
  input  logic [32*NUM_SFX-1:0]       sfx_tone,
  input  logic [8*NUM_SFX-1:0]        sfx_len,
  output logic [31:0]                 tone,
  output logic [9:0]                  duty,
  output logic [NUM_SFX-1:0]          grant,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(NUM_SFX)-1:0]  done_id
);

  localparam int IW = $clog2(NUM_SFX);
  localparam logic [LEN_W-1:0] GAP_LOAD = LEN_W'(GAP_TICKS);

  state_e               state_q;
  logic [LEN_W-1:0]     cnt_q;
  logic [NUM_SFX-1:0]   pending_q;
  logic [IW-1:0]        cur_q;
  logic [TONE_W-1:0]    tone_q;
  logic [DUTY_W-1:0]    duty_q;
  logic [NUM_SFX-1:0]   grant_q;
  logic                 busy_q;
  logic                 done_q;
  logic [IW-1:0]        done_id_q;

  logic [TONE_W-1:0]    tone_arr [NUM_SFX];
  logic [LEN_W-1:0]     len_arr  [NUM_SFX];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SFX; gi++) begin : g_unpack
      assign tone_arr[gi] = sfx_tone[TONE_W*gi +: TONE_W];
      assign len_arr[gi]  = sfx_len[LEN_W*gi +: LEN_W];
    end
  endgenerate

  // One picker serves both initial arbitration and preemption: the lowest
  // candidate index preempts only if it is strictly below the current one.
  logic [NUM_SFX-1:0] cand;
  logic [NUM_SFX-1:0] pick_oh;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;

  assign cand = pending_q | sfx_req;

  prio_pick #(.N(NUM_SFX)) u_pick (
    .req_i    (cand),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  logic preempt;
  logic last_tick;
  assign preempt   = pick_valid && (pick_idx < cur_q);
  assign last_tick = tick && (cnt_q == LEN_W'(1));

  // Transition decode; the register block below applies the chosen action.
  logic do_start, do_idle, do_gap, do_done;

  always_comb begin
    do_start = 1'b0;
    do_idle  = 1'b0;
    do_gap   = 1'b0;
    do_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        do_start = pick_valid;
        do_idle  = !pick_valid;
      end
      ST_PLAY: begin
        // Preemption outranks a coinciding final tick: no done issued.
        if (preempt) begin
          do_start = 1'b1;
        end else if (last_tick) begin
          do_done = 1'b1;
          if (GAP_TICKS == 0) begin
            do_start = pick_valid;
            do_idle  = !pick_valid;
          end else begin
            do_gap = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (last_tick) begin
          do_start = pick_valid;
          do_idle  = !pick_valid;
        end
      end
      default: do_idle = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pending_q <= '0;
      cur_q     <= '0;
      tone_q    <= '0;
      duty_q    <= DUTY_OFF;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
    end else begin
      done_q <= do_done;
      if (do_done) done_id_q <= cur_q;

      // Newly granted requester leaves pending; a preempted one was already
      // cleared at its own grant, so it is simply dropped.
      pending_q <= do_start ? (cand & ~pick_oh) : cand;

      if (do_start) begin
        state_q <= ST_PLAY;
        cur_q   <= pick_idx;
        grant_q <= pick_oh;
        cnt_q   <= len_floor(len_arr[pick_idx]);
        tone_q  <= tone_arr[pick_idx];
        duty_q  <= DUTY_ON;
        busy_q  <= 1'b1;
      end else if (do_idle) begin
        state_q <= ST_IDLE;
        grant_q <= '0;
        busy_q  <= 1'b0;
        tone_q  <= music_en ? music_tone : '0;
        duty_q  <= music_en ? DUTY_ON : DUTY_OFF;
      end else if (do_gap) begin
        state_q <= ST_GAP;
        grant_q <= '0;
        cnt_q   <= GAP_LOAD;
        tone_q  <= '0;
        duty_q  <= DUTY_OFF;
        busy_q  <= 1'b1;
      end else if (tick && cnt_q != '0) begin
        cnt_q <= cnt_q - LEN_W'(1);
      end
    end
  end

  assign tone    = tone_q;
  assign duty    = duty_q;
  assign grant   = grant_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;

endmodule

// File: tb/tb_sfx_tone_arbiter.sv
// tb_sfx_tone_arbiter
// Directed bench for sfx_tone_arbiter with default parameters
// (NUM_SFX=4, GAP_TICKS=1, DUTY_ON=512).
module tb_sfx_tone_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         tick;
  logic [31:0]  music_tone;
  logic         music_en;
  logic [3:0]   sfx_req;
  logic [127:0] sfx_tone;
  logic [31:0]  sfx_len;
  logic [31:0]  tone;
  logic [9:0]   duty;
  logic [3:0]   grant;
  logic         busy;
  logic         done;
  logic [1:0]   done_id;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sfx_tone_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .music_tone (music_tone),
    .music_en   (music_en),
    .sfx_req    (sfx_req),
    .sfx_tone   (sfx_tone),
    .sfx_len    (sfx_len),
    .tone       (tone),
    .duty       (duty),
    .grant      (grant),
    .busy       (busy),
    .done       (done),
    .done_id    (done_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full output snapshot: tone, duty, grant, busy, done.
  task automatic chk_out(input string tag, input logic [31:0] t, input logic [9:0] d,
                         input logic [3:0] g, input logic b, input logic dn);
    chk({tag, ".tone"},  tone,  t);
    chk({tag, ".duty"},  32'(duty), 32'(d));
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".busy"},  32'(busy), 32'(b));
    chk({tag, ".done"},  32'(done), 32'(dn));
    $display("step %-14s tone=%0d duty=%0d grant=%b busy=%0b done=%0b id=%0d",
             tag, tone, duty, grant, busy, done, done_id);
  endtask

  // One clock: inputs set beforehand apply to this edge, strobes then drop.
  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick    = 1'b0;
    sfx_req = '0;
  endtask

  initial begin
    reset      = 1'b0;
    tick       = 1'b0;
    music_tone = 32'd523;
    music_en   = 1'b1;
    sfx_req    = '0;
    // idx3=300/4, idx2=880/3, idx1=200/2, idx0=100/2
    sfx_tone   = {32'd300, 32'd880, 32'd200, 32'd100};
    sfx_len    = {8'd4, 8'd3, 8'd2, 8'd2};

    // Reset state
    cyc(0); cyc(0);
    chk_out("reset", 0, 0, 4'b0000, 0, 0);
    chk("reset.id", 32'(done_id), 0);
    reset = 1'b1;
    cyc(0);
    chk_out("idle_music", 523, 512, 4'b0000, 0, 0);

    // Single SFX, index 2, len 3
    sfx_req = 4'b0100; cyc(0);
    chk_out("s2_start", 880, 512, 4'b0100, 1, 0);
    cyc(0);
    chk_out("s2_notick", 880, 512, 4'b0100, 1, 0);
    cyc(1); chk_out("s2_t1", 880, 512, 4'b0100, 1, 0);
    cyc(1); chk_out("s2_t2", 880, 512, 4'b0100, 1, 0);
    cyc(1); chk_out("s2_done", 0, 0, 4'b0000, 1, 1);
    chk("s2_done.id", 32'(done_id), 2);
    cyc(0); chk_out("s2_gap", 0, 0, 4'b0000, 1, 0);
    cyc(1); chk_out("s2_idle", 523, 512, 4'b0000, 0, 0);

    // Simultaneous requests 1 and 3
    sfx_req = 4'b1010; cyc(0);
    chk_out("sim_i1", 200, 512, 4'b0010, 1, 0);
    cyc(1); chk_out("sim_i1_t1", 200, 512, 4'b0010, 1, 0);
    cyc(1); chk_out("sim_i1_done", 0, 0, 4'b0000, 1, 1);
    chk("sim_i1.id", 32'(done_id), 1);
    cyc(1); chk_out("sim_i3", 300, 512, 4'b1000, 1, 0);
    cyc(1); cyc(1); cyc(1);
    chk_out("sim_i3_t3", 300, 512, 4'b1000, 1, 0);
    cyc(1); chk_out("sim_i3_done", 0, 0, 4'b0000, 1, 1);
    chk("sim_i3.id", 32'(done_id), 3);
    cyc(1); chk_out("sim_idle", 523, 512, 4'b0000, 0, 0);

    // Preemption of index 3 by index 0
    sfx_req = 4'b1000; cyc(0);
    chk_out("pre_i3", 300, 512, 4'b1000, 1, 0);
    cyc(1);
    sfx_req = 4'b0001; cyc(0);
    chk_out("pre_i0", 100, 512, 4'b0001, 1, 0);
    cyc(1); chk_out("pre_i0_t1", 100, 512, 4'b0001, 1, 0);
    cyc(1); chk_out("pre_i0_done", 0, 0, 4'b0000, 1, 1);
    chk("pre_i0.id", 32'(done_id), 0);
    cyc(1); chk_out("pre_idle", 523, 512, 4'b0000, 0, 0);

    // Length 0 plays exactly one tick
    sfx_len[23:16] = 8'd0;
    sfx_req = 4'b0100; cyc(0);
    chk_out("len0_start", 880, 512, 4'b0100, 1, 0);
    cyc(1); chk_out("len0_done", 0, 0, 4'b0000, 1, 1);
    cyc(1); chk_out("len0_idle", 523, 512, 4'b0000, 0, 0);

    // Preemption in the same cycle as the final tick
    sfx_len[23:16] = 8'd1;
    sfx_req = 4'b0100; cyc(0);
    chk_out("pvf_start", 880, 512, 4'b0100, 1, 0);
    sfx_req = 4'b0001; cyc(1);
    chk_out("pvf_pre", 100, 512, 4'b0001, 1, 0);
    cyc(1); cyc(1);
    chk_out("pvf_done", 0, 0, 4'b0000, 1, 1);
    chk("pvf_done.id", 32'(done_id), 0);
    cyc(1); chk_out("pvf_idle", 523, 512, 4'b0000, 0, 0);

    // Retrigger from the current index replays after the gap
    sfx_len[23:16] = 8'd3;
    sfx_req = 4'b0100; cyc(0);
    cyc(1);
    sfx_req = 4'b0100; cyc(0);
    chk_out("rt_cont", 880, 512, 4'b0100, 1, 0);
    cyc(1); chk_out("rt_t2", 880, 512, 4'b0100, 1, 0);
    cyc(1); chk_out("rt_done", 0, 0, 4'b0000, 1, 1);
    cyc(1); chk_out("rt_replay", 880, 512, 4'b0100, 1, 0);
    cyc(1); cyc(1); cyc(1);
    chk_out("rt_done2", 0, 0, 4'b0000, 1, 1);
    cyc(1); chk_out("rt_idle", 523, 512, 4'b0000, 0, 0);

    // Mute
    music_en = 1'b0; cyc(0);
    chk_out("mute_idle", 0, 0, 4'b0000, 0, 0);
    sfx_req = 4'b0001; cyc(0);
    chk_out("mute_sfx", 100, 512, 4'b0001, 1, 0);
    cyc(1); cyc(1);
    chk_out("mute_done", 0, 0, 4'b0000, 1, 1);
    cyc(1); chk_out("mute_back", 0, 0, 4'b0000, 0, 0);

    // Asynchronous reset mid-play
    music_en = 1'b1;
    sfx_req = 4'b1000; cyc(0);
    chk_out("rst_play", 300, 512, 4'b1000, 1, 0);
    #2 reset = 1'b0;
    #1 chk_out("rst_async", 0, 0, 4'b0000, 0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    cyc(0);
    chk_out("rst_release", 523, 512, 4'b0000, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
